// File: rtl/uart_rx_buffer.sv
// Receive-side buffer for a UART: edge-detects frame/error strobes, queues clean
// frames in a first-word-fall-through FIFO and keeps sticky overflow/error statistics.
module uart_rx_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  data_valid,
    input  logic                  par_err,
    input  logic                  stp_err,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  RD_VALID,
    input  logic                  RD_READY,
    output logic                  FULL,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic                  OVF,
    output logic [CNT_WIDTH-1:0]  DROP_CNT,
    output logic [CNT_WIDTH-1:0]  ERR_CNT,
    input  logic                  CLR
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_reg;
    logic [ADDR_WIDTH-1:0] rd_ptr_reg;
    logic [ADDR_WIDTH:0]   count_reg;
    logic                  dv_reg;
    logic                  err_reg;
    logic                  block_reg;
    logic                  ovf_reg;
    logic [CNT_WIDTH-1:0]  drop_cnt_reg;
    logic [CNT_WIDTH-1:0]  err_cnt_reg;

    logic err_now;
    logic frame_evt;
    logic err_evt;
    logic clean_frame;
    logic pop;
    logic push;
    logic drop;

    assign RD_VALID = (count_reg != '0);
    assign FULL     = (count_reg == FULL_COUNT);
    assign COUNT    = count_reg;
    assign OVF      = ovf_reg;
    assign DROP_CNT = drop_cnt_reg;
    assign ERR_CNT  = err_cnt_reg;
    // Masked so an empty FIFO (including right after reset) always presents zero.
    assign RD_DATA  = RD_VALID ? mem[rd_ptr_reg] : '0;

    // block_reg suppresses a data_valid level that was already high when reset released.
    assign err_now     = par_err | stp_err;
    assign frame_evt   = data_valid & ~dv_reg & ~block_reg;
    assign err_evt     = err_now & ~err_reg;
    assign clean_frame = frame_evt & ~err_now;
    assign pop         = RD_VALID & RD_READY;
    assign push        = clean_frame & (~FULL | pop);
    assign drop        = clean_frame & FULL & ~pop;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr_reg] <= P_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            dv_reg     <= 1'b0;
            err_reg    <= 1'b0;
            block_reg  <= 1'b1;
        end else begin
            dv_reg  <= data_valid;
            err_reg <= err_now;
            if (!data_valid) begin
                block_reg <= 1'b0;
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + ADDR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + ADDR_WIDTH'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + (ADDR_WIDTH+1)'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - (ADDR_WIDTH+1)'(1);
            end
        end
    end

    // Statistics: CLR wins over any same-cycle increment or overflow set.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ovf_reg      <= 1'b0;
            drop_cnt_reg <= '0;
            err_cnt_reg  <= '0;
        end else if (CLR) begin
            ovf_reg      <= 1'b0;
            drop_cnt_reg <= '0;
            err_cnt_reg  <= '0;
        end else begin
            if (drop) begin
                ovf_reg <= 1'b1;
                if (drop_cnt_reg != '1) begin
                    drop_cnt_reg <= drop_cnt_reg + CNT_WIDTH'(1);
                end
            end
            if (err_evt && (err_cnt_reg != '1)) begin
                err_cnt_reg <= err_cnt_reg + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer: table of single-frame vectors plus
// hand-written sequences for fill/overflow, full push+pop, saturation, CLR and reset.
module tb_uart_rx_buffer;

    logic       clk;
    logic       rst;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic       full;
    logic [3:0] count;
    logic       ovf;
    logic [7:0] drop_cnt;
    logic [7:0] err_cnt;
    logic       clr;

    int tests;
    int fails;
    logic [7:0] q[$];

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       se;
        int         exp_count;
        int         exp_err;
        int         exp_drop;
    } vec_t;

    vec_t vecs[6];

    uart_rx_buffer #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .CNT_WIDTH(8)) dut (
        .CLK(clk), .RST(rst), .P_DATA(p_data), .data_valid(data_valid),
        .par_err(par_err), .stp_err(stp_err), .RD_DATA(rd_data), .RD_VALID(rd_valid),
        .RD_READY(rd_ready), .FULL(full), .COUNT(count), .OVF(ovf),
        .DROP_CNT(drop_cnt), .ERR_CNT(err_cnt), .CLR(clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clean or erroneous frame: strobe for one cycle, then idle one cycle.
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic se);
        p_data     = d;
        data_valid = 1'b1;
        par_err    = pe;
        stp_err    = se;
        if (!pe && !se && q.size() < 8) q.push_back(d);
        tick();
        data_valid = 1'b0;
        par_err    = 1'b0;
        stp_err    = 1'b0;
        tick();
        $display("[TB] frame data=%h pe=%b se=%b count=%0d err=%0d drop=%0d",
                 d, pe, se, count, err_cnt, drop_cnt);
    endtask

    task automatic pop_check();
        logic [7:0] exp_d;
        rd_ready = 1'b1;
        check("pop_valid", {31'b0, rd_valid}, 32'd1);
        if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL pop_model: got pop request expected non-empty model");
        end else begin
            exp_d = q.pop_front();
            check("pop_data", {24'b0, rd_data}, {24'b0, exp_d});
            $display("[TB] pop data=%h expected=%h", rd_data, exp_d);
        end
        tick();
        rd_ready = 1'b0;
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        vecs[0] = '{8'h11, 1'b0, 1'b0, 1, 0, 0};
        vecs[1] = '{8'h3C, 1'b1, 1'b0, 1, 1, 0};
        vecs[2] = '{8'h5A, 1'b0, 1'b1, 1, 2, 0};
        vecs[3] = '{8'h66, 1'b1, 1'b1, 1, 3, 0};
        vecs[4] = '{8'h22, 1'b0, 1'b0, 2, 3, 0};
        vecs[5] = '{8'h33, 1'b0, 1'b0, 3, 3, 0};

        rst = 1'b0; p_data = 8'h00; data_valid = 1'b0; par_err = 1'b0;
        stp_err = 1'b0; rd_ready = 1'b0; clr = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();

        check("rst_valid", {31'b0, rd_valid}, 32'd0);
        check("rst_full", {31'b0, full}, 32'd0);
        check("rst_count", {28'b0, count}, 32'd0);
        check("rst_data", {24'b0, rd_data}, 32'd0);
        check("rst_ovf", {31'b0, ovf}, 32'd0);
        check("rst_drop", {24'b0, drop_cnt}, 32'd0);
        check("rst_err", {24'b0, err_cnt}, 32'd0);

        // Single frame, one-cycle latency, held while not ready.
        p_data = 8'hA5; data_valid = 1'b1;
        q.push_back(8'hA5);
        tick();
        data_valid = 1'b0;
        check("lat_valid", {31'b0, rd_valid}, 32'd1);
        check("lat_data", {24'b0, rd_data}, 32'hA5);
        check("lat_count", {28'b0, count}, 32'd1);
        repeat (5) tick();
        check("hold_valid", {31'b0, rd_valid}, 32'd1);
        check("hold_data", {24'b0, rd_data}, 32'hA5);
        check("hold_count", {28'b0, count}, 32'd1);
        pop_check();
        check("empty_count", {28'b0, count}, 32'd0);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("ready_empty_count", {28'b0, count}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, vecs[i].pe, vecs[i].se);
            check("vec_count", {28'b0, count}, vecs[i].exp_count);
            check("vec_err", {24'b0, err_cnt}, vecs[i].exp_err);
            check("vec_drop", {24'b0, drop_cnt}, vecs[i].exp_drop);
        end
        while (q.size() > 0) pop_check();
        check("vec_drain_count", {28'b0, count}, 32'd0);

        clr_pulse();
        check("clr_err", {24'b0, err_cnt}, 32'd0);
        par_err = 1'b1; clr = 1'b1;
        tick();
        par_err = 1'b0; clr = 1'b0;
        tick();
        check("clr_prio_err", {24'b0, err_cnt}, 32'd0);

        // Fill to full, then one more frame overflows.
        for (int i = 0; i < 8; i++) send_frame(8'(i), 1'b0, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b0);
        check("ovf_full", {31'b0, full}, 32'd1);
        check("ovf_count", {28'b0, count}, 32'd8);
        check("ovf_flag", {31'b0, ovf}, 32'd1);
        check("ovf_drop", {24'b0, drop_cnt}, 32'd1);
        clr_pulse();
        check("clr_ovf", {31'b0, ovf}, 32'd0);
        check("clr_drop", {24'b0, drop_cnt}, 32'd0);
        check("clr_keep_count", {28'b0, count}, 32'd8);

        // Push and pop in the same cycle while full.
        p_data = 8'h77; data_valid = 1'b1; rd_ready = 1'b1;
        check("fullpp_head", {24'b0, rd_data}, {24'b0, q[0]});
        tick();
        void'(q.pop_front());
        q.push_back(8'h77);
        data_valid = 1'b0; rd_ready = 1'b0;
        check("fullpp_count", {28'b0, count}, 32'd8);
        check("fullpp_ovf", {31'b0, ovf}, 32'd0);
        check("fullpp_drop", {24'b0, drop_cnt}, 32'd0);
        tick();
        while (q.size() > 0) pop_check();
        check("fullpp_drain", {28'b0, count}, 32'd0);

        // Error counter saturation, then CLR leaves the FIFO alone.
        send_frame(8'hB1, 1'b0, 1'b0);
        send_frame(8'hB2, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            par_err = 1'b1;
            tick();
            par_err = 1'b0;
            tick();
        end
        check("sat_err", {24'b0, err_cnt}, 32'd255);
        clr_pulse();
        check("sat_clr_err", {24'b0, err_cnt}, 32'd0);
        check("sat_clr_drop", {24'b0, drop_cnt}, 32'd0);
        check("sat_clr_ovf", {31'b0, ovf}, 32'd0);
        check("sat_clr_count", {28'b0, count}, 32'd2);
        check("sat_clr_head", {24'b0, rd_data}, 32'hB1);

        // Asynchronous reset mid-operation with data_valid held high.
        send_frame(8'hC3, 1'b0, 1'b0);
        check("pre_rst_count", {28'b0, count}, 32'd3);
        data_valid = 1'b1;
        p_data = 8'h5E;
        rst = 1'b0;
        #1;
        check("arst_valid", {31'b0, rd_valid}, 32'd0);
        check("arst_count", {28'b0, count}, 32'd0);
        check("arst_full", {31'b0, full}, 32'd0);
        check("arst_data", {24'b0, rd_data}, 32'd0);
        q.delete();
        tick();
        tick();
        rst = 1'b1;
        repeat (3) tick();
        check("held_dv_count", {28'b0, count}, 32'd0);
        data_valid = 1'b0;
        tick();
        p_data = 8'h99; data_valid = 1'b1;
        tick();
        check("rearm_count", {28'b0, count}, 32'd1);
        check("rearm_data", {24'b0, rd_data}, 32'h99);
        q.push_back(8'h99);
        data_valid = 1'b0;
        tick();
        pop_check();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_buffer.md
UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, frame data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, log2 of FIFO depth (DEPTH = 2**ADDR_WIDTH).
REQ-003 SHALL have parameter CNT_WIDTH, default 8, width of the drop and error counters.
REQ-004 SHALL have port CLK  input  1  single clock for all logic.
REQ-005 SHALL have port RST  input  1  asynchronous active-low reset.
REQ-006 SHALL have port P_DATA  input  DATA_WIDTH  received frame data from the UART receiver.
REQ-007 SHALL have port data_valid  input  1  frame-complete indication from the receiver, level.
REQ-008 SHALL have port par_err  input  1  parity error indication, level.
REQ-009 SHALL have port stp_err  input  1  stop error indication, level.
REQ-010 SHALL have port RD_DATA  output  DATA_WIDTH  head-of-FIFO data, first-word-fall-through.
REQ-011 SHALL have port RD_VALID  output  1  RD_DATA holds a valid entry.
REQ-012 SHALL have port RD_READY  input  1  consumer accepts RD_DATA.
REQ-013 SHALL have port FULL  output  1  FIFO holds DEPTH entries.
REQ-014 SHALL have port COUNT  output  ADDR_WIDTH+1  number of stored entries.
REQ-015 SHALL have port OVF  output  1  sticky overflow flag.
REQ-016 SHALL have port DROP_CNT  output  CNT_WIDTH  frames dropped because the FIFO was full.
REQ-017 SHALL have port ERR_CNT  output  CNT_WIDTH  frames flagged with a parity or stop error.
REQ-018 SHALL have port CLR  input  1  synchronous clear of OVF, DROP_CNT and ERR_CNT.

Function
REQ-019 SHALL register data_valid and (par_err|stp_err) each cycle; a frame event is data_valid=1 with registered data_valid=0, and an error event is (par_err|stp_err)=1 with the registered error value=0.
REQ-020 SHALL push P_DATA on a frame event only if par_err=0, stp_err=0 and the FIFO is not full, or it is full with a pop in the same cycle.
REQ-021 SHALL, on a frame event while par_err or stp_err is 1, not push.
REQ-022 SHALL make a pushed entry visible on RD_DATA/RD_VALID in the cycle after the push when the FIFO was empty (1-cycle latency).
REQ-023 SHALL pop the head entry when RD_VALID=1 and RD_READY=1 at a clock edge; RD_READY with RD_VALID=0 has no effect.
REQ-024 SHALL hold RD_DATA stable while RD_VALID=1 and RD_READY=0.
REQ-025 SHALL, on simultaneous push and pop, perform both with COUNT unchanged, including when full.
REQ-026 SHALL wrap read and write pointers modulo DEPTH; COUNT ranges 0..DEPTH; RD_VALID = (COUNT!=0); FULL = (COUNT==DEPTH).
REQ-027 SHALL, on a clean frame event while full with no pop, drop the frame, set OVF=1, and increment DROP_CNT.
REQ-028 SHALL increment ERR_CNT by one per error event.
REQ-029 SHALL saturate DROP_CNT and ERR_CNT at all-ones and never wrap.
REQ-030 SHALL give CLR priority over same-cycle increments and the OVF set; CLR leaves FIFO contents and pointers untouched.
REQ-031 SHALL keep the FIFO contents unaffected by CLR and by error events.

Reset
REQ-032 SHALL, on RST=0 (asynchronous, mid-operation included), clear pointers, COUNT, OVF, DROP_CNT, ERR_CNT and both edge registers to 0, giving RD_VALID=0, FULL=0 and RD_DATA=0.
REQ-033 SHALL not treat data_valid held at 1 across reset release as a frame event.
REQ-034 SHALL have storage array contents that are don't-care after reset.

Verification
REQ-035 SHALL pass scenario: single clean frame P_DATA=0xA5 with RD_READY=0 -> one cycle later RD_VALID=1, RD_DATA=0xA5, COUNT=1; hold 5 cycles -> unchanged.
REQ-036 SHALL pass scenario: 8 clean frames 0x00..0x07 then a 9th 0xFF, RD_READY=0 -> FULL=1, COUNT=8, OVF=1, DROP_CNT=1; drain -> 0x00..0x07 in order.
REQ-037 SHALL pass scenario: frame with par_err=1 -> no push, ERR_CNT=1; frame with stp_err=1 -> ERR_CNT=2, COUNT=0.
REQ-038 SHALL pass scenario: FIFO full with a frame event and RD_READY=1 in the same cycle -> COUNT stays 8, OVF=0, last entry appears at the tail.
REQ-039 SHALL pass scenario: 300 error events -> ERR_CNT=255; CLR pulse -> ERR_CNT=0, DROP_CNT=0, OVF=0, COUNT unchanged.
REQ-040 SHALL pass scenario: RST asserted with COUNT=3 and data_valid held at 1 -> all outputs 0 immediately; after release, no push until data_valid returns to 0 and rises again.
